wb_arbiter: RTL and testbench

//  Writeback-port arbiter in front of the register file write port (a3/wd3/we3).

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_arbiter.sv | 107 ++++++++++
 tb/tb_wb_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

    // Data width carried by a queued writeback request.
    localparam int WB_XLEN = 32;

    // Register x0 is hard-wired to zero and never written.
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; DEPTH must be a power of two so the
// pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // Status flags and qualified push/pop strobes.
    always_comb begin
        full    = (count == COUNT_FULL);
        empty   = (count == '0);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: merges single-cycle ALU results and queued
// long-latency results into the registered regfile write port, with a
// starvation counter that eventually forces the queue head through.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3,
    output logic            lu_pending
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    wb_req_t       fifo_head;
    wb_req_t       lu_req;
    logic [SW-1:0] starve_cnt;
    logic          wr_en;
    wb_req_t       wr_req;

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (lu_req),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (fifo_head)
    );

    // Handshake and stall signals, derived from registered state only.
    always_comb begin
        lu_pending = !fifo_empty;
        lu_ready   = !reset && !fifo_full;
        alu_stall  = !reset && lu_pending && (starve_cnt == STARVE_MAX);
        fifo_push  = lu_valid && lu_ready && (lu_rd != REG_ZERO);
        lu_req     = '{rd: lu_rd, data: lu_data};
    end

    // Priority selection: starved queue head, then ALU, then queue head.
    always_comb begin
        fifo_pop = 1'b0;
        wr_en    = 1'b0;
        wr_req   = '0;
        if (alu_stall) begin
            fifo_pop = 1'b1;
            wr_en    = 1'b1;
            wr_req   = fifo_head;
        end else if (alu_valid && (alu_rd != REG_ZERO)) begin
            wr_en  = 1'b1;
            wr_req = '{rd: alu_rd, data: alu_data};
        end else if (lu_pending) begin
            fifo_pop = 1'b1;
            wr_en    = 1'b1;
            wr_req   = fifo_head;
        end
    end

    // Starvation counter: counts ALU wins over a waiting queue head.
    always_ff @(posedge clk) begin
        if (reset || fifo_empty) begin
            starve_cnt <= '0;
        end else if (fifo_pop) begin
            starve_cnt <= '0;
        end else if (wr_en && (starve_cnt < STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered regfile write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else if (wr_en) begin
            we3 <= 1'b1;
            a3  <= wr_req.rd;
            wd3 <= wr_req.data;
        end else begin
            we3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_stall;
    logic            lu_valid;
    logic            lu_ready;
    logic [4:0]      lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic            lu_pending;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [4:0]      q_rd   [$];
    logic [XLEN-1:0] q_data [$];
    int              starve;
    logic            m_we;
    logic [4:0]      m_a3;
    logic [XLEN-1:0] m_wd;

    always #5 clk = ~clk;

    wb_arbiter #(
        .XLEN(XLEN),
        .FIFO_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_rd     (lu_rd),
        .lu_data   (lu_data),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .lu_pending(lu_pending)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic av, input logic [4:0] ard,
                         input logic [XLEN-1:0] ad, input logic lv,
                         input logic [4:0] lrd, input logic [XLEN-1:0] ld);
        reset     = rst;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lu_valid  = lv;
        lu_rd     = lrd;
        lu_data   = ld;
    endtask

    // One clock: compare DUT against the model mid-cycle, advance the model
    // from the applied inputs, then return just after the rising edge.
    task automatic cycle();
        bit exp_ready;
        bit exp_stall;
        bit had_entries;
        @(negedge clk);
        exp_ready   = !reset && (q_rd.size() < DEPTH);
        exp_stall   = !reset && (q_rd.size() > 0) && (starve == LIMIT);
        had_entries = (q_rd.size() > 0);
        check("we3", 64'(we3), 64'(m_we));
        check("a3", 64'(a3), 64'(m_a3));
        check("wd3", 64'(wd3), 64'(m_wd));
        check("lu_ready", 64'(lu_ready), 64'(exp_ready));
        check("alu_stall", 64'(alu_stall), 64'(exp_stall));
        check("lu_pending", 64'(lu_pending), 64'(had_entries));
        if (reset) begin
            q_rd.delete();
            q_data.delete();
            starve = 0;
            m_we   = 1'b0;
            m_a3   = '0;
            m_wd   = '0;
        end else begin
            if (exp_stall) begin
                m_we   = 1'b1;
                m_a3   = q_rd.pop_front();
                m_wd   = q_data.pop_front();
                starve = 0;
            end else if (alu_valid && alu_rd != 5'd0) begin
                m_we = 1'b1;
                m_a3 = alu_rd;
                m_wd = alu_data;
                if (had_entries && starve < LIMIT) starve++;
            end else if (had_entries) begin
                m_we   = 1'b1;
                m_a3   = q_rd.pop_front();
                m_wd   = q_data.pop_front();
                starve = 0;
            end else begin
                m_we = 1'b0;
            end
            if (!had_entries) starve = 0;
            if (lu_valid && exp_ready && lu_rd != 5'd0) begin
                q_rd.push_back(lu_rd);
                q_data.push_back(lu_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        starve = 0;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd   = '0;
        @(posedge clk);
        #1;

        // Reset held for two cycles, then release.
        cycle();
        cycle();
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        cycle();
        check("rst_release_ready", 64'(lu_ready), 64'd1);

        // ALU only.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        cycle();
        check("alu_we3", 64'(we3), 64'd1);
        check("alu_a3", 64'(a3), 64'd5);
        check("alu_wd3", 64'(wd3), 64'hDEADBEEF);
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        cycle();

        // x0 suppression: ALU rd=0 lets the queued rd=9 through.
        drive(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        cycle();
        drive(1'b0, 1'b1, 5'd0, 32'h44, 1'b0, 5'd0, '0);
        cycle();
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        cycle();
        check("x0_alu_a3", 64'(a3), 64'd9);
        drive(1'b0, 1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h55);
        cycle();
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        cycle();
        check("x0_lu_pending", 64'(lu_pending), 64'd0);

        // Starvation: ALU writes every cycle while rd=7 waits.
        drive(1'b0, 1'b1, 5'd3, 32'h3, 1'b1, 5'd7, 32'h11);
        cycle();
        drive(1'b0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, '0);
        for (int i = 0; i < 8; i++) cycle();
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        cycle();

        // Full and pointer wrap, three rounds.
        for (int r = 0; r < 3; r++) begin
            drive(1'b0, 1'b1, 5'd4, 32'(r), 1'b1, 5'd1, 32'(100 + r));
            cycle();
            drive(1'b0, 1'b1, 5'd4, 32'(r), 1'b1, 5'd2, 32'(200 + r));
            cycle();
            drive(1'b0, 1'b1, 5'd4, 32'(r), 1'b1, 5'd6, 32'(300 + r));
            cycle();
            drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
            for (int i = 0; i < 3; i++) cycle();
        end

        // Reset while two entries are queued.
        drive(1'b0, 1'b1, 5'd8, 32'h8, 1'b1, 5'd10, 32'hA);
        cycle();
        drive(1'b0, 1'b1, 5'd8, 32'h8, 1'b1, 5'd11, 32'hB);
        cycle();
        drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        cycle();
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        for (int i = 0; i < 3; i++) cycle();
        check("midrst_we3", 64'(we3), 64'd0);
        check("midrst_a3", 64'(a3), 64'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(63) == 0),
                  ($urandom_range(3) != 0),
                  (($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31))),
                  32'($urandom()),
                  ($urandom_range(1) == 1),
                  (($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31))),
                  32'($urandom()));
            cycle();
        end
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        for (int i = 0; i < 4; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
